// File: rtl/bit_perm_stream_if.sv
// Valid/ready stream bundle for bit_perm_stream. The slave modport is the unit's view
// and the master modport is the view of whatever drives it.
interface bit_perm_stream_if #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned W = LANE_W * LANES;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_mode_err;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode_err, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode_err, beat_cnt
  );
endinterface

// File: rtl/bit_perm_stream.sv
// Streaming bit-permutation unit: pass, lane reverse, in-lane and full bit reverse, with a
// two-entry output/skid buffer. Defining BIT_PERM_TRANSPOSE_EN adds the mode-100 transpose.
module bit_perm_stream #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  bit_perm_stream_if.slave s_if
);
  localparam int unsigned W = LANE_W * LANES;

  // State bits are literally {out_valid, skid_valid}, so both handshake outputs are flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     perm_data_c;
  logic             perm_err_c;
  logic             accept_c;
  logic             deliver_c;

`ifdef BIT_PERM_TRANSPOSE_EN
  if (LANE_W != LANES) begin : g_bad_cfg
    $error("bit_perm_stream: transpose requires LANE_W == LANES");
  end
`endif

  // Permutation network on the input side.
  always_comb begin
    perm_data_c = s_if.in_data;
    perm_err_c  = 1'b0;
    case (s_if.in_mode)
      3'b000: ;
      3'b001: begin
        for (int k = 0; k < LANES; k++) begin
          perm_data_c[k*LANE_W +: LANE_W] = s_if.in_data[(LANES-1-k)*LANE_W +: LANE_W];
        end
      end
      3'b010: begin
        for (int k = 0; k < LANES; k++) begin
          for (int b = 0; b < LANE_W; b++) begin
            perm_data_c[k*LANE_W+b] = s_if.in_data[k*LANE_W+LANE_W-1-b];
          end
        end
      end
      3'b011: begin
        for (int i = 0; i < W; i++) begin
          perm_data_c[i] = s_if.in_data[W-1-i];
        end
      end
`ifdef BIT_PERM_TRANSPOSE_EN
      3'b100: begin
        for (int r = 0; r < LANES; r++) begin
          for (int c = 0; c < LANE_W; c++) begin
            perm_data_c[r*LANE_W+c] = s_if.in_data[c*LANE_W+r];
          end
        end
      end
`endif
      default: perm_err_c = 1'b1;
    endcase
  end

  assign accept_c  = s_if.in_valid & ~state_q[0];
  assign deliver_c = state_q[1] & s_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_c) state_d = ONE;
      ONE: begin
        if (accept_c && !deliver_c)      state_d = FULL;
        else if (!accept_c && deliver_c) state_d = EMPTY;
      end
      FULL:    if (deliver_c) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Steering: new beats go to the output register when it is free or draining, else to skid.
  always_comb begin
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    cnt_d       = cnt_q;
    if (deliver_c) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          out_data_d = perm_data_c;
          out_err_d  = perm_err_c;
        end
      end
      ONE: begin
        if (accept_c && deliver_c) begin
          out_data_d = perm_data_c;
          out_err_d  = perm_err_c;
        end else if (accept_c) begin
          skid_data_d = perm_data_c;
          skid_err_d  = perm_err_c;
        end
      end
      FULL: begin
        if (deliver_c) begin
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign s_if.in_ready     = ~state_q[0];
  assign s_if.out_valid    = state_q[1];
  assign s_if.out_data     = out_data_q;
  assign s_if.out_mode_err = out_err_q;
  assign s_if.beat_cnt     = cnt_q;

endmodule

// File: tb/tb_bit_perm_stream.sv
// Directed bench for bit_perm_stream: permutation modes, backpressure, counter wrap and
// mid-stream reset, using a 64-bit default instance and a CNT_W=4 instance.
module tb_bit_perm_stream;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  bit_perm_stream_if #(.LANE_W(8), .LANES(8), .CNT_W(16)) bus0 ();
  bit_perm_stream_if #(.LANE_W(8), .LANES(8), .CNT_W(4))  bus1 ();

  bit_perm_stream #(.LANE_W(8), .LANES(8), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus0.slave)
  );

  bit_perm_stream #(.LANE_W(8), .LANES(8), .CNT_W(4)) dut_w4 (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat through an empty unit with out_ready=1: present after accept, gone after delivery.
  task automatic send_one(input string tag, input logic [2:0] mode, input logic [63:0] data,
                          input logic [63:0] exp_data, input logic exp_err,
                          input logic [15:0] exp_cnt);
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.in_mode   = mode;
    bus0.in_data   = data;
    step();
    bus0.in_valid = 1'b0;
    bus0.in_mode  = 3'b111;
    check({tag, "_data"}, bus0.out_data, exp_data);
    check({tag, "_err"}, 64'(bus0.out_mode_err), 64'(exp_err));
    step();
    check({tag, "_cnt"}, 64'(bus0.beat_cnt), 64'(exp_cnt));
  endtask

  initial begin
    int          sent;
    int          got;
    int          cyc;
    int          first_del;
    int          last_del;
    logic        acc;
    logic        del;
    logic        stalled;
    logic [63:0] held;
    logic [63:0] exp_tr;
    logic        exp_tr_err;

    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.in_mode   = 3'b000;
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_mode   = 3'b000;
    bus1.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("rst_beat_cnt", 64'(bus0.beat_cnt), 64'd0);
    check("rst_out_data", bus0.out_data, 64'd0);
    check("rst_mode_err", 64'(bus0.out_mode_err), 64'd0);
    rst = 1'b0;

    send_one("lane_rev", 3'b001, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301, 1'b0, 16'd1);
    send_one("lane_bitrev", 3'b010, 64'h1, 64'h80, 1'b0, 16'd2);
    send_one("full_rev", 3'b011, 64'h1, 64'h8000000000000000, 1'b0, 16'd3);
    send_one("bad_mode", 3'b111, 64'h1, 64'h1, 1'b1, 16'd4);
`ifdef BIT_PERM_TRANSPOSE_EN
    exp_tr     = 64'h0101010101010101;
    exp_tr_err = 1'b0;
`else
    exp_tr     = 64'h00000000000000FF;
    exp_tr_err = 1'b1;
`endif
    send_one("transpose", 3'b100, 64'hFF, exp_tr, exp_tr_err, 16'd5);

    // Backpressure: beats 1..4 offered back-to-back, out_ready held low for 3 cycles.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    first_del = -1;
    last_del  = -1;
    while (got < 4 && cyc < 40) begin
      bus0.in_valid  = (sent < 4);
      bus0.in_data   = 64'(sent + 1);
      bus0.in_mode   = 3'b000;
      bus0.out_ready = (cyc >= 3);
      acc     = bus0.in_valid & bus0.in_ready;
      del     = bus0.out_valid & bus0.out_ready;
      stalled = bus0.out_valid & ~bus0.out_ready;
      held    = bus0.out_data;
      if (del) begin
        check("bp_order", bus0.out_data, 64'(got + 1));
        got++;
        if (first_del < 0) first_del = cyc;
        last_del = cyc;
      end
      step();
      if (acc) sent++;
      if (stalled) check("bp_stall_hold", bus0.out_data, held);
      if (acc && sent == 2) check("bp_in_ready_low", 64'(bus0.in_ready), 64'd0);
      cyc++;
    end
    bus0.in_valid = 1'b0;
    check("bp_delivered", 64'(got), 64'd4);
    check("bp_no_gaps", 64'(last_del - first_del), 64'd3);
    check("bp_beat_cnt", 64'(bus0.beat_cnt), 64'd4);
    step();
    check("bp_drained", 64'(bus0.out_valid), 64'd0);

    // Mid-stream reset with A and B held; inputs during reset must be ignored.
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_mode   = 3'b000;
    bus0.in_data   = 64'hAAAA;
    step();
    bus0.in_data = 64'hBBBB;
    step();
    check("mr_full", 64'(bus0.in_ready), 64'd0);
    rst            = 1'b1;
    bus0.in_data   = 64'hCCCC;
    bus0.out_ready = 1'b1;
    step();
    check("mr_out_valid", 64'(bus0.out_valid), 64'd0);
    check("mr_in_ready", 64'(bus0.in_ready), 64'd1);
    check("mr_beat_cnt", 64'(bus0.beat_cnt), 64'd0);
    check("mr_out_data", bus0.out_data, 64'd0);
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_no_stale", 64'(bus0.out_valid), 64'd0);
    end
    send_one("mr_new_beat", 3'b001, 64'h00000000000000DD, 64'hDD00000000000000, 1'b0, 16'd1);

    // Counter wrap on the CNT_W=4 instance: 17 deliveries at full rate.
    sent = 0;
    got  = 0;
    cyc  = 0;
    bus1.out_ready = 1'b1;
    while (got < 17 && cyc < 60) begin
      bus1.in_valid = (sent < 17);
      bus1.in_data  = 64'(sent);
      acc = bus1.in_valid & bus1.in_ready;
      del = bus1.out_valid & bus1.out_ready;
      step();
      if (acc) sent++;
      if (del) begin
        got++;
        if (got == 15) check("wrap_cnt_15", 64'(bus1.beat_cnt), 64'd15);
        if (got == 16) check("wrap_cnt_16", 64'(bus1.beat_cnt), 64'd0);
        if (got == 17) check("wrap_cnt_17", 64'(bus1.beat_cnt), 64'd1);
      end
      cyc++;
    end
    bus1.in_valid = 1'b0;
    check("wrap_delivered", 64'(got), 64'd17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
